instr_fetch: RTL

Instruction fetch stage: it owns the program counter, issues reads to a synchronous instruction memory, and delivers instruction words with their PC to decode through a valid/ready handshake. It is the producing end of the `opCode` path: decode and control consume `instr`/`opCode` from this block. It also accepts a PC redirect from the branch resolution logic (`branch` together with the ALU zero flag).

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_buf.sv | 41 ++++
 rtl/instr_fetch.sv | 95 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: widths, opcode field, reset PC, FSM encoding.
package fetch_pkg;
    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam int OP_HI   = 31;
    localparam int OP_LO   = 26;

    localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;

    localparam logic [0:0] STATE_RUN  = 1'b0;
    localparam logic [0:0] STATE_DROP = 1'b1;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetchEntry_t;

    function automatic logic [PC_W-1:0] alignPc(input logic [PC_W-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction
endpackage

// File: rtl/fetch_buf.sv
// Two-entry {pc, instr} FIFO between the memory response and decode; clear beats push.
module fetch_buf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        push,
    input  fetchEntry_t pushData,
    input  logic        pop,
    output logic [1:0]  count,
    output fetchEntry_t head
);
    fetchEntry_t mem [2];
    logic        rdPtr;
    logic        wrPtr;
    logic        doPush;
    logic        doPop;

    assign doPop  = pop && (count != 2'd0);
    assign doPush = push && !clear && ((count != 2'd2) || doPop);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= 2'd0;
            rdPtr <= 1'b0;
            wrPtr <= 1'b0;
        end else begin
            if (doPush) wrPtr <= ~wrPtr;
            if (doPop)  rdPtr <= ~rdPtr;
            count <= count + {1'b0, doPush} - {1'b0, doPop};
        end
    end

    // Storage carries no reset; the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

    assign head = (count != 2'd0) ? mem[rdPtr] : '0;
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC sequencing, synchronous imem reads, redirect flush, valid/ready to decode.
// Optional FETCH_COUNT_EN adds the fetchCount accepted-instruction counter.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imemRead,
    output logic [PC_W-1:0]    imemAddr,
    input  logic [INSTR_W-1:0] imemData,
    output logic [INSTR_W-1:0] instr,
    output logic [5:0]         opCode,
    output logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    pcPlus4,
    output logic               instrValid,
    input  logic               instrReady,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirectPc
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0]        fetchCount
`endif
);
    logic [PC_W-1:0] fetchPc;
    logic [PC_W-1:0] issuedPc_p1;
    logic            inflight_p1;
    logic [0:0]      state;
    logic [1:0]      count;
    logic [2:0]      occupancy;
    logic            pop;
    logic            push;
    logic            issue;
    fetchEntry_t     head;
    fetchEntry_t     pushEntry;

    assign pop       = (count != 2'd0) && instrReady && !redirect;
    assign occupancy = {1'b0, count} + {2'b00, inflight_p1} - {2'b00, pop};
    assign issue     = !rst && !redirect && (occupancy < 3'd2);

    // Stage p0: issue the read for fetchPc.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetchPc     <= RESET_PC;
            inflight_p1 <= 1'b0;
            state       <= STATE_RUN;
        end else begin
            inflight_p1 <= issue;
            if (redirect) begin
                fetchPc <= alignPc(redirectPc);
                state   <= inflight_p1 ? STATE_DROP : STATE_RUN;
            end else begin
                state <= STATE_RUN;
                if (issue) fetchPc <= fetchPc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue) issuedPc_p1 <= fetchPc;
    end

    // Stage p1: memory data returns and is paired with the PC it was issued for.
    assign push            = inflight_p1 && (state == STATE_RUN);
    assign pushEntry.pc    = issuedPc_p1;
    assign pushEntry.instr = imemData;

    fetch_buf u_buf (
        .clk      (clk),
        .rst      (rst),
        .clear    (redirect),
        .push     (push),
        .pushData (pushEntry),
        .pop      (pop),
        .count    (count),
        .head     (head)
    );

    // Stage p2: FIFO head presented to decode.
    assign imemRead   = issue;
    assign imemAddr   = fetchPc;
    assign instrValid = (count != 2'd0) && !redirect;
    assign instr      = head.instr;
    assign opCode     = head.instr[OP_HI:OP_LO];
    assign pc         = head.pc;
    assign pcPlus4    = (count != 2'd0) ? head.pc + 32'd4 : '0;

`ifdef FETCH_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst)      fetchCount <= 32'd0;
        else if (pop) fetchCount <= fetchCount + 32'd1;
    end
`endif
endmodule
